// File: rtl/encoder_4to2_seq_if.sv
// Encoded-index stream between encoder_4to2_seq and its consumer.
// The multi flag exists only when ENC_MULTI_ERR_EN is defined.
interface encoder_4to2_seq_if #(
    parameter int W = 2
) ();
    logic [W-1:0] x;
    logic         valid;
    logic         ready;
`ifdef ENC_MULTI_ERR_EN
    logic         multi;
`endif

    modport master (
        output x,
        output valid,
        input  ready
`ifdef ENC_MULTI_ERR_EN
        ,
        output multi
`endif
    );

    modport slave (
        input  x,
        input  valid,
        output ready
`ifdef ENC_MULTI_ERR_EN
        ,
        input  multi
`endif
    );
endinterface

// File: rtl/encoder_4to2_seq.sv
// Registered priority encoder with sticky pending set and valid/ready output.
// Optional ENC_MULTI_ERR_EN adds a registered multi-hot request flag.
module encoder_4to2_seq #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        m,
    encoder_4to2_seq_if.master  bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state, state_n;
    logic [W-1:0] x_q, x_n;
    logic [N-1:0] pend, pend_n;
    logic [N-1:0] a;
    logic [N-1:0] sel_bit;
    logic [W-1:0] sel;
    logic         free;

    // Highest set index of the merged request set wins.
    always_comb begin
        a       = pend | m;
        sel     = '0;
        sel_bit = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (a[i]) sel = W'(i);
        end
        sel_bit[sel] = 1'b1;
    end

    always_comb begin
        state_n = state;
        x_n     = x_q;
        pend_n  = a;
        free    = (state == IDLE) || bus.ready;
        if (free) begin
            if (a != '0) begin
                state_n = HOLD;
                x_n     = sel;
                pend_n  = a & ~sel_bit;
            end else begin
                state_n = IDLE;
                pend_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            x_q   <= '0;
            pend  <= '0;
        end else begin
            state <= state_n;
            x_q   <= x_n;
            pend  <= pend_n;
        end
    end

    assign bus.x     = x_q;
    assign bus.valid = (state == HOLD);

`ifdef ENC_MULTI_ERR_EN
    logic multi_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) multi_q <= 1'b0;
        else       multi_q <= ($countones(m) > 1);
    end

    assign bus.multi = multi_q;
`endif
endmodule

// File: tb/tb_encoder_4to2_seq.sv
// Scoreboard bench for encoder_4to2_seq: a behavioural model pushes the
// expected post-edge outputs for each driven cycle; they are popped after the edge.
module tb_encoder_4to2_seq;
    logic       clk;
    logic       reset;
    logic [3:0] m;

    encoder_4to2_seq_if #(.W(2)) bus ();

    encoder_4to2_seq #(.N(4), .W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .m     (m),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [1:0] x;
        logic       mu;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;

    // Reference state
    logic [3:0] mdl_p;
    logic       mdl_v;
    logic [1:0] mdl_x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_p = 4'b0;
        mdl_v = 1'b0;
        mdl_x = 2'd0;
    endtask

    // Called at the negedge: drive inputs, predict, cross the edge, compare.
    task automatic step(input logic [3:0] mi, input logic ri);
        logic [3:0] a;
        exp_t       e;
        exp_t       got;
        int         hi;
        m         = mi;
        bus.ready = ri;
        a  = mdl_p | mi;
        hi = -1;
        for (int i = 3; i >= 0; i--) begin
            if (a[i] && hi < 0) hi = i;
        end
        if (!mdl_v || ri) begin
            if (hi >= 0) begin
                mdl_v = 1'b1;
                mdl_x = 2'(hi);
                mdl_p = a;
                mdl_p[hi] = 1'b0;
            end else begin
                mdl_v = 1'b0;
                mdl_p = 4'b0;
            end
        end else begin
            mdl_p = a;
        end
        e.v  = mdl_v;
        e.x  = mdl_x;
        e.mu = ($countones(mi) > 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("valid", 32'(bus.valid), 32'(got.v));
        check("x", 32'(bus.x), 32'(got.x));
`ifdef ENC_MULTI_ERR_EN
        check("multi", 32'(bus.multi), 32'(got.mu));
`endif
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        m         = 4'b0;
        bus.ready = 1'b0;
        model_reset();
        #3;
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_x", 32'(bus.x), 32'd0);
`ifdef ENC_MULTI_ERR_EN
        check("rst_multi", 32'(bus.multi), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        idle(3);

        // Single request
        step(4'b0010, 1'b1);
        check("t2_x", 32'(bus.x), 32'd1);
        idle(2);

        // Two requests in one cycle, highest first
        step(4'b1001, 1'b1);
        check("t3_x_first", 32'(bus.x), 32'd3);
        step(4'b0000, 1'b1);
        check("t3_x_second", 32'(bus.x), 32'd0);
        idle(2);

        // Stall accumulates requests
        step(4'b0100, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        check("t4_hold_x", 32'(bus.x), 32'd2);
        step(4'b0000, 1'b1);
        check("t4_x_after", 32'(bus.x), 32'd0);
        idle(2);

        // Request for the index on x is re-presented; same-edge accept merges
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        idle(2);

        // Async reset mid-cycle with pending requests
        step(4'b0100, 1'b0);
        step(4'b0011, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t5_valid", 32'(bus.valid), 32'd0);
        check("t5_x", 32'(bus.x), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        idle(4);

        // Multi-hot and single-hot flag behaviour
        step(4'b0110, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b1);
        idle(2);

        // Randomised sparse traffic with random back-pressure
        for (int k = 0; k < 300; k++) begin
            logic [3:0] mr;
            mr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            step(mr, ($urandom_range(0, 3) != 0));
        end
        idle(6);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
